// File: rtl/motor_command_shaper.sv
// ---------------------------------------------------------------------------
// motor_command_shaper
//
// Turns the channel decoder's signed power command into a ramp-limited PWM
// duty magnitude plus a direction bit for the H-bridge PWM generator. A
// direction reversal first ramps the duty down, then holds zero duty for a
// programmable dead-time before the direction bit flips. A latched brake
// request parks the bridge in brake. A loss-of-signal watchdog forces
// braking until a neutral, non-braking sample arrives.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_timebase     single-cycle tick; all ramp/dead-time/watchdog timing
//                  counts these ticks
//   i_power_valid  single-cycle strobe qualifying i_power/i_brake/i_boost
//   i_power        signed power command, negative means reverse
//   i_brake        brake request, sampled with i_power_valid
//   i_boost        boost request (lifts the normal ceiling), sampled with
//                  i_power_valid
//   i_normal_max   duty ceiling while boost is inactive
//   i_ramp_step    maximum duty change per tick (0 freezes the duty)
//   i_deadtime     ticks of zero duty between direction changes
//   i_timeout      ticks without a valid sample before failsafe, 0 disables
//   o_duty         PWM duty magnitude
//   o_dir          0 forward, 1 reverse
//   o_brake_en     bridge brake (both low sides on)
//   o_failsafe     watchdog tripped
// ---------------------------------------------------------------------------
module motor_command_shaper #(
    parameter int K_RES = 10,
    parameter int K_WDW = 16,
    parameter int K_DTW = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_timebase,
    input  logic                    i_power_valid,
    input  logic signed [K_RES-1:0] i_power,
    input  logic                    i_brake,
    input  logic                    i_boost,
    input  logic [K_RES-2:0]        i_normal_max,
    input  logic [K_RES-2:0]        i_ramp_step,
    input  logic [K_DTW-1:0]        i_deadtime,
    input  logic [K_WDW-1:0]        i_timeout,
    output logic [K_RES-2:0]        o_duty,
    output logic                    o_dir,
    output logic                    o_brake_en,
    output logic                    o_failsafe
);

    localparam int DW = K_RES - 1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_REV_RAMP,
        ST_DEADTIME,
        ST_BRAKE,
        ST_FAILSAFE
    } state_t;

    state_t           state;
    logic [DW-1:0]    mag_lat;
    logic             req_dir;
    logic             brake_lat;
    logic             boost_lat;
    logic [K_WDW-1:0] wd_cnt;
    logic [K_DTW-1:0] dt_cnt;

    logic [K_RES-1:0] neg_power;
    logic [DW-1:0]    sample_mag;
    logic             sample_zero;
    logic [DW-1:0]    target;
    logic             wd_trip;
    logic [K_RES-1:0] duty_ext;
    logic [K_RES-1:0] step_ext;
    logic [K_RES-1:0] tgt_ext;
    logic [K_RES-1:0] up_sum;
    logic [K_RES-1:0] dn_floor;
    logic [DW-1:0]    ramp_next;
    logic [DW-1:0]    decay_next;

    // Magnitude of the incoming command. The most negative code has no
    // positive twin at this width, so its negation still has the sign bit
    // set; that case saturates to the largest representable magnitude.
    always_comb begin
        neg_power  = ~i_power + K_RES'(1);
        sample_mag = i_power[DW-1:0];
        if (i_power[K_RES-1]) begin
            if (neg_power[K_RES-1]) begin
                sample_mag = '1;
            end else begin
                sample_mag = neg_power[DW-1:0];
            end
        end
        sample_zero = (sample_mag == '0);
    end

    // The ceiling is applied from the latched magnitude and boost flag, so
    // the effective target equals the clamped sample and also follows any
    // later change of i_normal_max.
    always_comb begin
        target = mag_lat;
        if (!boost_lat && (mag_lat > i_normal_max)) begin
            target = i_normal_max;
        end
        wd_trip = (i_timeout != '0) && (wd_cnt >= i_timeout);
    end

    // One ramp step toward the target, done one bit wider than the duty so
    // that neither duty+step nor target+step can wrap. Landing on the target
    // whenever the step would reach or pass it prevents overshoot.
    always_comb begin
        duty_ext   = {1'b0, o_duty};
        step_ext   = {1'b0, i_ramp_step};
        tgt_ext    = {1'b0, target};
        up_sum     = duty_ext + step_ext;
        dn_floor   = tgt_ext + step_ext;
        ramp_next  = o_duty;
        if (o_duty < target) begin
            ramp_next = (up_sum >= tgt_ext) ? target : up_sum[DW-1:0];
        end else if (o_duty > target) begin
            ramp_next = (duty_ext <= dn_floor) ? target : (o_duty - i_ramp_step);
        end
        decay_next = (o_duty > i_ramp_step) ? (o_duty - i_ramp_step) : '0;
    end

    // Sample latch and watchdog. A zero-magnitude sample carries no sign
    // information, so the requested direction is left alone. A valid strobe
    // clears the watchdog even when a tick lands in the same cycle, and the
    // counter parks at all-ones instead of wrapping back below the timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag_lat   <= '0;
            req_dir   <= 1'b0;
            brake_lat <= 1'b0;
            boost_lat <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            if (i_power_valid) begin
                mag_lat   <= sample_mag;
                brake_lat <= i_brake;
                boost_lat <= i_boost;
                if (!sample_zero) begin
                    req_dir <= i_power[K_RES-1];
                end
            end
            if (i_power_valid) begin
                wd_cnt <= '0;
            end else if (i_timebase && (wd_cnt != '1)) begin
                wd_cnt <= wd_cnt + K_WDW'(1);
            end
        end
    end

    // Main shaping FSM with registered outputs. Failsafe is left only on a
    // live neutral, non-braking sample, checked straight off the inputs so
    // the exit happens on the strobe itself. Outside failsafe the order is
    // watchdog trip, then latched brake, then the reversal sequence, then
    // normal ramping. A reversal always passes through DEADTIME, which is
    // where the direction bit actually flips.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_RUN;
            dt_cnt     <= '0;
            o_duty     <= '0;
            o_dir      <= 1'b0;
            o_brake_en <= 1'b0;
            o_failsafe <= 1'b0;
        end else if (state == ST_FAILSAFE) begin
            o_duty <= '0;
            if (i_power_valid && sample_zero && !i_brake) begin
                state      <= ST_RUN;
                o_brake_en <= 1'b0;
                o_failsafe <= 1'b0;
            end
        end else if (wd_trip) begin
            state      <= ST_FAILSAFE;
            o_duty     <= '0;
            o_brake_en <= 1'b1;
            o_failsafe <= 1'b1;
        end else if (brake_lat) begin
            state      <= ST_BRAKE;
            o_duty     <= '0;
            o_brake_en <= 1'b1;
        end else begin
            case (state)
                ST_BRAKE: begin
                    state      <= ST_RUN;
                    o_duty     <= '0;
                    o_brake_en <= 1'b0;
                end
                ST_RUN: begin
                    if (req_dir != o_dir) begin
                        if (o_duty != '0) begin
                            state <= ST_REV_RAMP;
                        end else begin
                            state  <= ST_DEADTIME;
                            dt_cnt <= i_deadtime;
                        end
                    end else if (i_timebase) begin
                        o_duty <= ramp_next;
                    end
                end
                ST_REV_RAMP: begin
                    if (req_dir == o_dir) begin
                        state <= ST_RUN;
                    end else if (o_duty == '0) begin
                        state  <= ST_DEADTIME;
                        dt_cnt <= i_deadtime;
                    end else if (i_timebase) begin
                        o_duty <= decay_next;
                    end
                end
                ST_DEADTIME: begin
                    o_duty <= '0;
                    if (dt_cnt == '0) begin
                        o_dir <= ~o_dir;
                        state <= ST_RUN;
                    end else if (i_timebase) begin
                        dt_cnt <= dt_cnt - K_DTW'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_command_shaper.sv
// ---------------------------------------------------------------------------
// tb_motor_command_shaper
//
// Directed bench for motor_command_shaper at K_RES=10. Ticks are issued
// one at a time (one tick clock followed by three idle clocks) and samples
// are single-clock strobes, so every expected duty/dir/brake/failsafe value
// below is worked out by hand from the command sequence.
// ---------------------------------------------------------------------------
module tb_motor_command_shaper;

    localparam int K_RES = 10;
    localparam int K_WDW = 16;
    localparam int K_DTW = 8;
    localparam int DW    = K_RES - 1;

    logic                    i_clk;
    logic                    i_rst_n;
    logic                    i_timebase;
    logic                    i_power_valid;
    logic signed [K_RES-1:0] i_power;
    logic                    i_brake;
    logic                    i_boost;
    logic [DW-1:0]           i_normal_max;
    logic [DW-1:0]           i_ramp_step;
    logic [K_DTW-1:0]        i_deadtime;
    logic [K_WDW-1:0]        i_timeout;
    logic [DW-1:0]           o_duty;
    logic                    o_dir;
    logic                    o_brake_en;
    logic                    o_failsafe;

    int checks;
    int failures;

    motor_command_shaper #(
        .K_RES(K_RES),
        .K_WDW(K_WDW),
        .K_DTW(K_DTW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_timebase   (i_timebase),
        .i_power_valid(i_power_valid),
        .i_power      (i_power),
        .i_brake      (i_brake),
        .i_boost      (i_boost),
        .i_normal_max (i_normal_max),
        .i_ramp_step  (i_ramp_step),
        .i_deadtime   (i_deadtime),
        .i_timeout    (i_timeout),
        .o_duty       (o_duty),
        .o_dir        (o_dir),
        .o_brake_en   (o_brake_en),
        .o_failsafe   (o_failsafe)
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: sequence did not complete");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Each wait ends one time unit after a rising edge, which is where
    // inputs are driven and outputs are sampled.
    task automatic waitClocks(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int pwr, input logic brk, input logic bst);
        i_power       = K_RES'(pwr);
        i_brake       = brk;
        i_boost       = bst;
        i_power_valid = 1'b1;
        waitClocks(1);
        i_power_valid = 1'b0;
        waitClocks(1);
    endtask

    task automatic applyTick();
        i_timebase = 1'b1;
        waitClocks(1);
        i_timebase = 1'b0;
        waitClocks(3);
    endtask

    task automatic applyReset();
        i_rst_n = 1'b0;
        waitClocks(2);
        i_rst_n = 1'b1;
        waitClocks(1);
    endtask

    task automatic checkOutput(input string tag, input int exp_duty, input logic exp_dir,
                               input logic exp_brake, input logic exp_fs);
        logic [DW+2:0] obs;
        logic [DW+2:0] expv;
        obs  = {o_duty, o_dir, o_brake_en, o_failsafe};
        expv = {DW'(exp_duty), exp_dir, exp_brake, exp_fs};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed duty=%0d dir=%0b brake_en=%0b failsafe=%0b, expected duty=%0d dir=%0b brake_en=%0b failsafe=%0b",
                   tag, o_duty, o_dir, o_brake_en, o_failsafe, exp_duty, exp_dir, exp_brake, exp_fs);
        end
    endtask

    // Directed sequence: reset, ramp, ceiling/boost, reversal, brake,
    // watchdog, corners, and an asynchronous reset in the middle of a
    // dead-time.
    initial begin
        checks        = 0;
        failures      = 0;
        i_rst_n       = 1'b0;
        i_timebase    = 1'b0;
        i_power_valid = 1'b0;
        i_power       = '0;
        i_brake       = 1'b0;
        i_boost       = 1'b0;
        i_normal_max  = 9'd511;
        i_ramp_step   = 9'd16;
        i_deadtime    = 8'd0;
        i_timeout     = 16'd0;

        waitClocks(2);
        checkOutput("reset_hold", 0, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b1;
        waitClocks(2);
        checkOutput("reset_release", 0, 1'b0, 1'b0, 1'b0);

        // Ramp up to +200 in steps of 16.
        applyStimulus(200, 1'b0, 1'b0);
        checkOutput("ramp_latch", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 13; i++) begin
            applyTick();
            checkOutput("ramp_up", (16 * i > 200) ? 200 : 16 * i, 1'b0, 1'b0, 1'b0);
        end
        repeat (2) applyTick();
        checkOutput("ramp_hold", 200, 1'b0, 1'b0, 1'b0);

        // Ceiling without boost, then with boost.
        i_normal_max = 9'd300;
        i_ramp_step  = 9'd100;
        applyStimulus(450, 1'b0, 1'b0);
        applyTick();
        checkOutput("clamp_normal", 300, 1'b0, 1'b0, 1'b0);
        applyTick();
        checkOutput("clamp_hold", 300, 1'b0, 1'b0, 1'b0);
        applyStimulus(450, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyTick();
            checkOutput("boost", (300 + 100 * i > 450) ? 450 : 300 + 100 * i, 1'b0, 1'b0, 1'b0);
        end

        // Most negative command with boost: decay to 0, zero dead-time,
        // then ramp in reverse up to the saturated magnitude 511.
        applyStimulus(-512, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            applyTick();
            checkOutput("neg_full_decay", (450 > 100 * i) ? 450 - 100 * i : 0,
                        (i == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 7; i++) begin
            applyTick();
            checkOutput("neg_full_ramp", (100 * i > 511) ? 511 : 100 * i, 1'b1, 1'b0, 1'b0);
        end

        // Reversal with a three-tick dead-time.
        applyReset();
        checkOutput("reset_between", 0, 1'b0, 1'b0, 1'b0);
        i_normal_max = 9'd511;
        i_ramp_step  = 9'd50;
        i_deadtime   = 8'd3;
        applyStimulus(200, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyTick();
            checkOutput("rev_fwd_ramp", 50 * i, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(-100, 1'b0, 1'b0);
        checkOutput("rev_latch", 200, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyTick();
            checkOutput("rev_decay", 200 - 50 * i, 1'b0, 1'b0, 1'b0);
        end
        // Duty stays 0 across three dead-time ticks; the flip becomes
        // visible one clock after the third tick empties the counter.
        for (int i = 1; i <= 3; i++) begin
            applyTick();
            checkOutput("rev_deadtime", 0, (i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 3; i++) begin
            applyTick();
            checkOutput("rev_new_dir", (50 * i > 100) ? 100 : 50 * i, 1'b1, 1'b0, 1'b0);
        end

        // Brake entry one clock after the latch, and release back to RUN.
        applyReset();
        i_ramp_step = 9'd100;
        applyStimulus(300, 1'b0, 1'b0);
        repeat (3) applyTick();
        checkOutput("brake_pre", 300, 1'b0, 1'b0, 1'b0);
        applyStimulus(300, 1'b1, 1'b0);
        checkOutput("brake_entry", 0, 1'b0, 1'b1, 1'b0);
        repeat (2) applyTick();
        checkOutput("brake_hold", 0, 1'b0, 1'b1, 1'b0);
        i_ramp_step = 9'd40;
        applyStimulus(100, 1'b0, 1'b0);
        checkOutput("brake_release", 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyTick();
            checkOutput("brake_ramp", (40 * i > 100) ? 100 : 40 * i, 1'b0, 1'b0, 1'b0);
        end

        // Watchdog trip after five silent ticks, and the exit rules.
        i_timeout = 16'd5;
        applyStimulus(100, 1'b0, 1'b0);
        checkOutput("wd_arm", 100, 1'b0, 1'b0, 1'b0);
        repeat (4) applyTick();
        checkOutput("wd_quiet", 100, 1'b0, 1'b0, 1'b0);
        applyTick();
        checkOutput("wd_trip", 0, 1'b0, 1'b1, 1'b1);
        applyStimulus(50, 1'b0, 1'b0);
        checkOutput("wd_nonzero_sample", 0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("wd_brake_sample", 0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("wd_exit", 0, 1'b0, 1'b0, 1'b0);

        // Valid and tick together on the would-be tripping tick.
        repeat (4) applyTick();
        i_power       = '0;
        i_brake       = 1'b0;
        i_boost       = 1'b0;
        i_power_valid = 1'b1;
        i_timebase    = 1'b1;
        waitClocks(1);
        i_power_valid = 1'b0;
        i_timebase    = 1'b0;
        waitClocks(3);
        repeat (4) applyTick();
        checkOutput("wd_tie_no_trip", 0, 1'b0, 1'b0, 1'b0);
        applyTick();
        checkOutput("wd_tie_retrip", 0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("wd_exit2", 0, 1'b0, 1'b0, 1'b0);
        i_timeout = 16'd0;
        repeat (10) applyTick();
        checkOutput("wd_disabled", 0, 1'b0, 1'b0, 1'b0);

        // Zero step freezes the duty; downward ramp lands without overshoot.
        i_ramp_step = 9'd40;
        applyStimulus(200, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            applyTick();
            checkOutput("freeze_pre", 40 * i, 1'b0, 1'b0, 1'b0);
        end
        i_ramp_step = 9'd0;
        repeat (3) applyTick();
        checkOutput("freeze", 80, 1'b0, 1'b0, 1'b0);
        i_ramp_step = 9'd50;
        applyStimulus(10, 1'b0, 1'b0);
        applyTick();
        checkOutput("ramp_down_step", 30, 1'b0, 1'b0, 1'b0);
        applyTick();
        checkOutput("ramp_down_land", 10, 1'b0, 1'b0, 1'b0);

        // Get into reverse, start a long dead-time back to forward, then
        // pull reset asynchronously in the middle of it.
        i_deadtime = 8'd3;
        applyStimulus(-100, 1'b0, 1'b0);
        applyTick();
        checkOutput("pre_rev_decay", 0, 1'b0, 1'b0, 1'b0);
        repeat (3) applyTick();
        checkOutput("pre_rev_deadtime", 0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            applyTick();
            checkOutput("pre_rev_ramp", 50 * i, 1'b1, 1'b0, 1'b0);
        end
        i_deadtime = 8'd20;
        applyStimulus(100, 1'b0, 1'b0);
        repeat (2) applyTick();
        applyTick();
        checkOutput("deadtime_hold", 0, 1'b1, 1'b0, 1'b0);
        #3;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 1'b0, 1'b0, 1'b0);
        waitClocks(2);
        i_rst_n = 1'b1;
        waitClocks(1);
        repeat (2) applyTick();
        checkOutput("post_reset_idle", 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_command_shaper.md
Name: motor_command_shaper

Overview:
- Downstream consumer of the channel decoder's power/brake/boost outputs.
- Converts the signed power command into a ramp-limited PWM duty magnitude plus a direction bit for the H-bridge PWM generator.
- Enforces a dead-time on direction reversal and holds a brake while commanded.
- Runs a loss-of-signal watchdog that forces braking until the stick returns to neutral.

Parameters:
- K_RES, 10, resolution of the incoming signed power command; duty is K_RES-1 bits.
- K_WDW, 16, width of the watchdog counter and timeout input.
- K_DTW, 8, width of the dead-time counter and input.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_timebase  in  1  single-cycle tick; all ramp/dead-time/watchdog timing counts ticks
- i_power_valid  in  1  single-cycle strobe: new i_power/i_brake/i_boost sample
- i_power  in  K_RES  signed two's-complement command; negative = reverse
- i_brake  in  1  brake request, sampled with i_power_valid
- i_boost  in  1  boost request, sampled with i_power_valid
- i_normal_max  in  K_RES-1  duty ceiling when boost is inactive
- i_ramp_step  in  K_RES-1  max duty change per tick
- i_deadtime  in  K_DTW  ticks with duty 0 between direction changes
- i_timeout  in  K_WDW  ticks without a valid sample before failsafe; 0 disables
- o_duty  out  K_RES-1  PWM duty magnitude
- o_dir  out  1  0 forward, 1 reverse
- o_brake_en  out  1  bridge brake (both low sides on)
- o_failsafe  out  1  watchdog tripped

Behaviour:
- Reset values:
  - All outputs 0.
  - State RUN; latched target, requested direction, latched brake and latched boost all 0.
  - Watchdog counter 0.
- Sample latch, on i_power_valid:
  - mag = |i_power|; -2^(K_RES-1) saturates to 2^(K_RES-1)-1.
  - target = boost ? mag : min(mag, i_normal_max).
  - Requested dir = i_power sign bit if mag != 0; unchanged if mag == 0.
  - Latched brake and boost are captured from the same strobe.
- Watchdog:
  - Counter increments on each tick, saturating at all-ones.
  - Cleared on i_power_valid; a valid strobe in the same cycle as a tick wins.
  - Trip when i_timeout != 0 and counter >= i_timeout.
- State priority: FAILSAFE > BRAKE > reversal > RUN.
- States:
  - RUN
    - On each tick, duty moves toward target by at most i_ramp_step, never overshooting.
    - Arithmetic is done at K_RES bits, so there is no wrap.
    - i_ramp_step = 0 freezes duty.
    - If requested dir != o_dir and o_duty != 0, go to REV_RAMP.
    - If requested dir != o_dir and o_duty == 0, go to DEADTIME.
  - REV_RAMP
    - Duty ramps toward 0 at i_ramp_step per tick.
    - When duty reaches 0, go to DEADTIME.
    - If the request flips back to o_dir before that, return to RUN.
  - DEADTIME
    - Counter loads i_deadtime on entry; o_duty = 0.
    - Counter decrements per tick.
    - When the counter is 0, toggle o_dir and go to RUN. With i_deadtime = 0 the stay is exactly one clock.
  - BRAKE
    - Entered from any non-failsafe state when latched brake = 1.
    - o_duty = 0 in the entry cycle; o_brake_en = 1.
    - When latched brake = 0, go to RUN with duty 0; o_dir is then updated via the normal reversal path.
  - FAILSAFE
    - Entered from any state on watchdog trip.
    - o_duty = 0, o_brake_en = 1, o_failsafe = 1.
    - Exit only on a valid sample with mag == 0 and i_brake == 0; then go to RUN with duty 0.
    - Samples that do not meet the exit condition keep the state, but still clear the watchdog.
- Output timing: all outputs registered; one clock from state/duty update to output.
- Mid-operation reset: immediate return to reset values.

Test Plan:
- Ramp up: K_RES=10, normal_max=511, step=16, power=+200, ticks every 4 clk -> duty 16,32,…,192,200 on consecutive ticks, then holds 200; dir=0.
- Boost clamp: normal_max=300, power=+450 boost=0 -> duty settles at 300. Same sample with boost=1 -> duty settles at 450. power=-512 -> magnitude 511.
- Reversal: duty=200 forward, power=-100, step=50, deadtime=3 -> duty 150,100,50,0. Then 3 ticks at 0 with dir=0. Then dir=1 and duty ramps 50,100.
- Brake: duty=300, valid sample with brake=1 -> o_duty=0 and brake_en=1 within 1 clk of latch. Brake=0 with power=+100 -> brake_en=0 and duty ramps from 0.
- Watchdog: timeout=5, no valid for 5 ticks -> failsafe=1, brake_en=1, duty=0. Sample power=+50 -> stays failsafe. Sample power=0 -> RUN, failsafe=0. timeout=0 -> never trips.
- Corners: valid and tick in the cycle the counter would trip -> no trip. step=0 -> duty frozen. Reset asserted mid-DEADTIME -> all outputs 0 asynchronously.
